// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
// Segment bit order is a,b,c,d,e,f,g,dp from bit 7 down to bit 0.
package seg_pkg;

   localparam logic [7:0] SEG_0 = 8'hFC;
   localparam logic [7:0] SEG_1 = 8'h60;
   localparam logic [7:0] SEG_2 = 8'hDA;
   localparam logic [7:0] SEG_3 = 8'hF2;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'hB6;
   localparam logic [7:0] SEG_6 = 8'hBE;
   localparam logic [7:0] SEG_7 = 8'hE0;
   localparam logic [7:0] SEG_8 = 8'hFE;
   localparam logic [7:0] SEG_9 = 8'hF6;

   localparam logic [7:0] SEG_OFF  = 8'h00;
   localparam logic [3:0] SEL_NONE = 4'b1111;
   localparam logic [4:0] VAL_BLANK = 5'b10000;

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } state_e;

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit decoder: bit 4 blanks, nibbles 10..15 are dark.
module seg_decoder
   import seg_pkg::*;
(
   input  logic [4:0] val,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (!val[4]) begin
         unique case (val[3:0])
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller with blanking gaps between digits.
// Outputs are registered from next-state values so they track the FSM edge.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int DWELL_CYC = 25000,
   parameter int BLANK_CYC = 250
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       en,
   input  logic       wr_en,
   input  logic [1:0] wr_idx,
   input  logic [4:0] wr_val,
   output logic [7:0] seg_dat,
   output logic [3:0] seg_sel,
   output logic       frame_tick
);

   localparam logic [19:0] DWELL_LAST = 20'(DWELL_CYC - 1);
   localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [19:0] cnt_q, cnt_d;
   logic [4:0]  dig_q [DIGITS];
   logic [4:0]  dig_d [DIGITS];
   logic [4:0]  act_q, act_d;
   logic [7:0]  seg_dat_q, seg_dat_d;
   logic [3:0]  seg_sel_q, seg_sel_d;
   logic        tick_q, tick_d;
   logic [7:0]  dec_seg;

   // Decoding the next active value lets seg_dat land on the SHOW edge.
   seg_decoder u_dec (
      .val (act_d),
      .seg (dec_seg)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 20'd1;
      act_d   = act_q;
      tick_d  = 1'b0;
      dig_d   = dig_q;
      if (wr_en) dig_d[wr_idx] = wr_val;

      if (!en) begin
         state_d = ST_BLANK;
         idx_d   = 2'd0;
         cnt_d   = 20'd0;
      end else begin
         unique case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = 20'd0;
                  act_d   = dig_q[idx_q];
               end
            end
            ST_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = 20'd0;
                  idx_d   = idx_q + 2'd1;
                  tick_d  = (idx_q == 2'd3);
               end
            end
            default: ;
         endcase
      end

      seg_sel_d = SEL_NONE;
      seg_dat_d = SEG_OFF;
      if (state_d == ST_SHOW) begin
         seg_sel_d = ~(4'b0001 << idx_d);
         seg_dat_d = dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (nRst) begin
         state_q   <= ST_BLANK;
         idx_q     <= 2'd0;
         cnt_q     <= 20'd0;
         act_q     <= VAL_BLANK;
         seg_dat_q <= SEG_OFF;
         seg_sel_q <= SEL_NONE;
         tick_q    <= 1'b0;
         for (int i = 0; i < DIGITS; i++) dig_q[i] <= VAL_BLANK;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         act_q     <= act_d;
         seg_dat_q <= seg_dat_d;
         seg_sel_q <= seg_sel_d;
         tick_q    <= tick_d;
         for (int i = 0; i < DIGITS; i++) dig_q[i] <= dig_d[i];
      end
   end

   assign seg_dat    = seg_dat_q;
   assign seg_sel    = seg_sel_q;
   assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be one per line as: name, default, meaning.
REQ-002 DIGITS, 4, number of multiplexed digits; fixed at 4 in this revision.
REQ-003 DWELL_CYC, 25000, clk cycles a digit is lit (1 ms at 25 MHz); legal range 1..2^20-1.
REQ-004 BLANK_CYC, 250, clk cycles all digits are dark between digits; legal range 1..2^16-1.
REQ-005 Ports SHALL be one per line as: name, direction, width, meaning.
REQ-006 clk, in, 1, 25 MHz system clock; every register samples on its rising edge.
REQ-007 nRst, in, 1, reset; synchronous, active-high.
REQ-008 en, in, 1, scan enable; low forces blanking.
REQ-009 wr_en, in, 1, single-cycle write strobe for a digit value.
REQ-010 wr_idx, in, 2, digit index written when wr_en=1.
REQ-011 wr_val, in, 5, value written: bit4 is blank; bits3:0 are the hex nibble.
REQ-012 seg_dat, out, 8, segment pattern, registered, active-high; bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-013 seg_sel, out, 4, digit select, registered, active-low; bit i drives digit i.
REQ-014 frame_tick, out, 1, one-cycle pulse when digit 3's SHOW period ends.

Function
REQ-015 FSM states SHALL be BLANK and SHOW, plus a 2-bit digit index idx and a cycle counter cnt.
REQ-016 BLANK SHALL last exactly BLANK_CYC cycles (cnt 0..BLANK_CYC-1), then go to SHOW with cnt=0.
REQ-017 SHOW SHALL last exactly DWELL_CYC cycles, then go to BLANK with idx=(idx+1) mod 4 and cnt=0.
REQ-018 A full frame SHALL be 4*(BLANK_CYC+DWELL_CYC) cycles; idx SHALL wrap from 3 to 0.
REQ-019 In BLANK, outputs SHALL be seg_sel=4'b1111 and seg_dat=8'h00.
REQ-020 In SHOW, seg_sel SHALL be ~(1<<idx) and seg_dat SHALL be the decode of the latched value.
REQ-021 Outputs SHALL change on the same edge as the state change, with no extra latency.
REQ-022 Decode for nibbles 0..9 SHALL be FC, 60, DA, F2, 66, B6, BE, E0, FE, F6 (hex).
REQ-023 Decode SHALL give 8'h00 for nibbles 10..15 and for any value with the blank bit set.
REQ-024 A write SHALL update digit register wr_idx on the clock edge where wr_en=1.
REQ-025 Writes SHALL be accepted in any state, with no stall.
REQ-026 A digit's value SHALL be captured into the active register on the BLANK->SHOW edge.
REQ-027 A write arriving during SHOW SHALL be shown only on that digit's next visit.
REQ-028 A write to the entering digit on the BLANK->SHOW edge itself SHALL be missed (old value shown); the new value appears on the next visit.
REQ-029 frame_tick SHALL assert for exactly the one cycle following the SHOW->BLANK edge where idx goes 3->0.
REQ-030 When en=0, the next edge SHALL force state=BLANK, idx=0 and cnt=0, and hold them; digit registers are unaffected.
REQ-031 When en returns to 1, scanning SHALL resume as from reset, with the first SHOW of digit 0 BLANK_CYC cycles later.
REQ-032 cnt width SHALL be 20 bits; all comparisons are against the parameter minus 1, with no overflow path.

Reset
REQ-033 nRst=1 at an edge SHALL set state=BLANK, idx=0, cnt=0, seg_sel=4'b1111, seg_dat=8'h00 and frame_tick=0.
REQ-034 nRst=1 at an edge SHALL set all digit registers and the active register to 5'b10000 (blank).
REQ-035 Reset SHALL override en and wr_en in the same cycle, including reset mid-SHOW and reset mid-write.

Structure
REQ-036 Package seg_pkg SHALL hold the 10 segment code constants, SEG_OFF=8'h00, SEL_NONE=4'b1111 and the state enum.
REQ-037 Combinational sub-module seg_decoder (5-bit value in, 8-bit pattern out) SHALL implement REQ-022 and REQ-023.
REQ-038 seg_scan_ctrl SHALL instantiate seg_decoder once, on the active register.

Verification (DWELL_CYC=4, BLANK_CYC=1)
REQ-039 Reset, then write 1,2,3,4 to idx0..3 with en=1 -> seg_sel sequence 1111,1110x4,1111,1101x4,... and seg_dat 60,DA,F2,66 in SHOW; frame_tick every 20 cycles.
REQ-040 Write wr_val=5'h07 to idx2 while idx2 is in SHOW -> E0 appears only on idx2's next visit, 20 cycles later.
REQ-041 Write 5'h0B to idx0, then 5'h15 to idx1 -> seg_dat=00 while idx0 and idx1 are selected.
REQ-042 Drop en mid-SHOW of idx1 -> next cycle seg_sel=1111; re-raise en -> idx0 is lit 1 cycle later.
REQ-043 Assert nRst for 1 cycle mid-SHOW of idx3 -> all outputs at reset values and digits blank until rewritten.
REQ-044 Write idx1 on the exact BLANK->SHOW edge of idx1 -> old value shown this visit, new value on the next.
